// File: rtl/game_pkg.sv
// Shared game definitions: difficulty codes, spawner states,
// LFSR taps and default gap lengths.
package game_pkg;

    localparam logic [1:0] DIFF_EASY = 2'b00;
    localparam logic [1:0] DIFF_MED  = 2'b01;
    localparam logic [1:0] DIFF_HARD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PICK,
        S_PROBE,
        S_FIRE
    } spawn_state_e;

    // Galois mask for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int GAP_W        = 28;
    localparam int GAP_EASY_DEF = 150_000_000;
    localparam int GAP_MED_DEF  = 100_000_000;
    localparam int GAP_HARD_DEF = 50_000_000;

    function automatic logic [4:0] ones16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads its seed on reset.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Decides when and where moles pop up: paced gaps, random hole pick,
// linear probe past raised moles, one-cycle spawn pulse.
module mole_spawner
    import game_pkg::*;
#(
    parameter int          NUM_HOLES = 8,
    parameter int          MAX_UP    = 3,
    parameter int          GAP_EASY  = GAP_EASY_DEF,
    parameter int          GAP_MED   = GAP_MED_DEF,
    parameter int          GAP_HARD  = GAP_HARD_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic                 enable,
    input  logic [1:0]           difficulty,
    input  logic [NUM_HOLES-1:0] mole_up,
    output logic [NUM_HOLES-1:0] mole,
    output logic [2:0]           moletime,
    output logic [7:0]           spawn_count
);

    localparam int HW = $clog2(NUM_HOLES);
    localparam logic [4:0] CAP = 5'(MAX_UP);
    localparam logic [HW-1:0] LAST_PROBE = HW'(NUM_HOLES - 1);

    spawn_state_e state, state_d;

    logic [GAP_W-1:0]     gap_cnt, gap_d;
    logic [GAP_W-1:0]     lim_m1, lim_d;
    logic [HW-1:0]        cand, cand_d;
    logic [HW-1:0]        probes, probes_d;
    logic [NUM_HOLES-1:0] mole_d;
    logic [2:0]           mt_d;
    logic [7:0]           cnt_d;
    logic [15:0]          lfsr;
    logic [15:0]          up_ext;
    logic [4:0]           ups;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .q     (lfsr)
    );

    assign up_ext = 16'(mole_up);
    assign ups    = ones16(up_ext);

    // Stored as limit-1 so the terminal compare is a plain equality.
    function automatic logic [GAP_W-1:0] gap_m1(input logic [1:0] d);
        unique case (d)
            DIFF_EASY: return GAP_W'(GAP_EASY - 1);
            DIFF_MED:  return GAP_W'(GAP_MED - 1);
            default:   return GAP_W'(GAP_HARD - 1);
        endcase
    endfunction

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            lim_m1      <= '0;
            cand        <= '0;
            probes      <= '0;
            mole        <= '0;
            moletime    <= '0;
            spawn_count <= '0;
        end else begin
            state       <= state_d;
            gap_cnt     <= gap_d;
            lim_m1      <= lim_d;
            cand        <= cand_d;
            probes      <= probes_d;
            mole        <= mole_d;
            moletime    <= mt_d;
            spawn_count <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        gap_d    = gap_cnt;
        lim_d    = lim_m1;
        cand_d   = cand;
        probes_d = probes;
        mole_d   = '0;
        mt_d     = moletime;
        cnt_d    = spawn_count;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    lim_d   = gap_m1(difficulty);
                    cnt_d   = '0;
                end
                S_GAP: begin
                    // Park at the limit while too many moles are up.
                    if (gap_cnt == lim_m1) begin
                        if (ups < CAP) begin
                            state_d = S_PICK;
                        end
                    end else begin
                        gap_d = gap_cnt + 1'b1;
                    end
                end
                S_PICK: begin
                    cand_d   = lfsr[HW-1:0];
                    probes_d = '0;
                    state_d  = S_PROBE;
                end
                S_PROBE: begin
                    if (!mole_up[cand]) begin
                        state_d      = S_FIRE;
                        mole_d[cand] = 1'b1;
                        mt_d         = lfsr[15:13];
                        if (spawn_count != 8'hFF) begin
                            cnt_d = spawn_count + 8'd1;
                        end
                    end else if (probes == LAST_PROBE) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        lim_d   = gap_m1(difficulty);
                    end else begin
                        cand_d   = cand + 1'b1;
                        probes_d = probes + 1'b1;
                    end
                end
                S_FIRE: begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    lim_d   = gap_m1(difficulty);
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized bench for mole_spawner against a timing/LFSR reference model.
`timescale 1ns/1ps
module tb_mole_spawner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] difficulty;
    logic [7:0] mole_up;
    logic [7:0] mole;
    logic [2:0] moletime;
    logic [7:0] spawn_count;
    logic [7:0] mole_up2;
    logic [7:0] mole2;
    logic [2:0] moletime2;
    logic [7:0] spawn_count2;

    int vecs = 0;
    int errs = 0;
    int cyc;
    logic [2:0] last_mt;
    logic [15:0] lfa [0:16383];

    always #5 clk = ~clk;

    mole_spawner #(
        .NUM_HOLES (8), .MAX_UP (8),
        .GAP_EASY (20), .GAP_MED (10), .GAP_HARD (5),
        .LFSR_SEED (16'hACE1)
    ) u_dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .enable      (enable),
        .difficulty  (difficulty),
        .mole_up     (mole_up),
        .mole        (mole),
        .moletime    (moletime),
        .spawn_count (spawn_count)
    );

    mole_spawner #(
        .NUM_HOLES (8), .MAX_UP (3),
        .GAP_EASY (20), .GAP_MED (10), .GAP_HARD (5),
        .LFSR_SEED (16'hACE1)
    ) u_cap (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .enable      (enable),
        .difficulty  (difficulty),
        .mole_up     (mole_up2),
        .mole        (mole2),
        .moletime    (moletime2),
        .spawn_count (spawn_count2)
    );

    // Edges seen since reset release; the LFSR value after edge n is lfa[n].
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int gap_of(input logic [1:0] d);
        if (d == 2'b00) return 20;
        if (d == 2'b01) return 10;
        return 5;
    endfunction

    // Gap starts after edge e; PICK after edge e+lim; one probe per busy hole.
    function automatic void predict(input int e, input int lim,
                                    input logic [7:0] mu,
                                    output int f, output int hole);
        logic [15:0] v;
        int c, j;
        v = lfa[e + lim];
        c = int'(v[2:0]);
        j = 0;
        while (j < 8 && mu[(c + j) % 8]) j++;
        f = e + lim + 2 + j;
        hole = (c + j) % 8;
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (mole !== 8'h00) begin
            errs++; $display("FAIL reset_mole got %h exp 00", mole);
        end
        vecs++;
        if (moletime !== 3'd0) begin
            errs++; $display("FAIL reset_moletime got %0d exp 0", moletime);
        end
        vecs++;
        if (spawn_count !== 8'd0) begin
            errs++; $display("FAIL reset_count got %0d exp 0", spawn_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic start_game(output int e);
        enable = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        vecs++;
        if (spawn_count !== 8'd0) begin
            errs++; $display("FAIL start_count got %0d exp 0", spawn_count);
        end
    endtask

    task automatic run_spawns(input int n, input logic [7:0] mu,
                              input int chg, input logic [1:0] nd,
                              inout int e, inout int cnt);
        int f, h, lim;
        logic [15:0] v;
        logic [7:0] em;
        for (int k = 0; k < n; k++) begin
            mole_up = mu;
            lim = gap_of(difficulty);
            predict(e, lim, mu, f, h);
            cnt = (cnt < 255) ? cnt + 1 : 255;
            while (cyc < f) begin
                if (k == 0 && chg > 0 && cyc == e + chg) difficulty = nd;
                vecs++;
                if (mole !== 8'h00) begin
                    errs++; $display("FAIL quiet_mole cyc=%0d got %h exp 00", cyc, mole);
                end
                @(negedge clk);
            end
            em = 8'b1 << h;
            v = lfa[f - 1];
            last_mt = v[15:13];
            vecs++;
            if (mole !== em) begin
                errs++; $display("FAIL pulse_mole cyc=%0d got %h exp %h", cyc, mole, em);
            end
            vecs++;
            if (moletime !== last_mt) begin
                errs++; $display("FAIL pulse_moletime got %0d exp %0d", moletime, last_mt);
            end
            vecs++;
            if (spawn_count !== 8'(cnt)) begin
                errs++; $display("FAIL pulse_count got %0d exp %0d", spawn_count, cnt);
            end
            @(negedge clk);
            vecs++;
            if (mole !== 8'h00) begin
                errs++; $display("FAIL pulse_width got %h exp 00", mole);
            end
            e = f + 1;
        end
    endtask

    task automatic test_reset();
        mole_up = 8'h00;
        mole_up2 = 8'h07;
        difficulty = 2'b01;
        do_reset();
    endtask

    task automatic test_first_spawn();
        int e, cnt;
        cnt = 0;
        difficulty = 2'b01;
        start_game(e);
        run_spawns(3, 8'h00, 0, 2'b01, e, cnt);
    endtask

    task automatic test_random();
        int e, cnt;
        logic [7:0] mu;
        do_reset();
        difficulty = 2'($urandom);
        start_game(e);
        cnt = 0;
        for (int r = 0; r < 10; r++) begin
            mu = 8'($urandom);
            if (mu == 8'hFF) mu = 8'h7F;
            run_spawns(1, mu, 2, 2'($urandom), e, cnt);
        end
    endtask

    task automatic test_blocked();
        int e, cnt, got;
        do_reset();
        difficulty = 2'b10;
        start_game(e);
        cnt = 0;
        run_spawns(3, 8'hFE, 0, 2'b10, e, cnt);
        mole_up = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            vecs++;
            if (mole !== 8'h00) begin
                errs++; $display("FAIL full_quiet got %h exp 00", mole);
            end
            @(negedge clk);
        end
        vecs++;
        if (spawn_count !== 8'(cnt)) begin
            errs++; $display("FAIL full_count got %0d exp %0d", spawn_count, cnt);
        end
        mole_up = 8'hFE;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (mole !== 8'h00) got = 1;
        end
        vecs++;
        if (mole !== 8'h01) begin
            errs++; $display("FAIL unblock_mole got %h exp 01", mole);
        end
        vecs++;
        if (spawn_count !== 8'(cnt + 1)) begin
            errs++; $display("FAIL unblock_count got %0d exp %0d", spawn_count, cnt + 1);
        end
    endtask

    task automatic test_cap();
        int got;
        do_reset();
        difficulty = 2'b10;
        mole_up = 8'h00;
        mole_up2 = 8'h07;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vecs++;
            if (mole2 !== 8'h00) begin
                errs++; $display("FAIL cap_quiet got %h exp 00", mole2);
            end
        end
        mole_up2 = 8'h06;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (mole2 !== 8'h00) got = 1;
        end
        vecs++;
        if (got != 1 || $countones(mole2) != 1 || (mole2 & 8'h06) != 8'h00) begin
            errs++; $display("FAIL cap_release got %h exp onehot outside 06", mole2);
        end
        vecs++;
        if (spawn_count2 !== 8'd1) begin
            errs++; $display("FAIL cap_count got %0d exp 1", spawn_count2);
        end
        mole_up2 = 8'h07;
    endtask

    task automatic test_diff_change();
        int e, cnt;
        do_reset();
        difficulty = 2'b00;
        start_game(e);
        cnt = 0;
        run_spawns(2, 8'h00, 5, 2'b10, e, cnt);
    endtask

    task automatic test_enable_drop();
        int e, cnt, f, h;
        do_reset();
        difficulty = 2'b01;
        start_game(e);
        cnt = 0;
        run_spawns(1, 8'h00, 0, 2'b01, e, cnt);
        predict(e, 10, 8'h00, f, h);
        while (cyc < f - 1) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vecs++;
            if (mole !== 8'h00) begin
                errs++; $display("FAIL drop_mole got %h exp 00", mole);
            end
        end
        vecs++;
        if (moletime !== last_mt) begin
            errs++; $display("FAIL drop_moletime got %0d exp %0d", moletime, last_mt);
        end
        vecs++;
        if (spawn_count !== 8'd1) begin
            errs++; $display("FAIL drop_count got %0d exp 1", spawn_count);
        end
        start_game(e);
        cnt = 0;
        run_spawns(1, 8'h00, 0, 2'b01, e, cnt);
    endtask

    task automatic test_saturate();
        int e, cnt;
        do_reset();
        difficulty = 2'b11;
        start_game(e);
        cnt = 0;
        run_spawns(258, 8'h00, 0, 2'b11, e, cnt);
    endtask

    task automatic test_reset_fire();
        int e, cnt, f, h;
        do_reset();
        difficulty = 2'b01;
        start_game(e);
        predict(e, 10, 8'h00, f, h);
        mole_up = 8'h00;
        while (cyc < f) @(negedge clk);
        vecs++;
        if (mole === 8'h00) begin
            errs++; $display("FAIL fire_seen got %h exp nonzero", mole);
        end
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        vecs++;
        if (mole !== 8'h00) begin
            errs++; $display("FAIL async_mole got %h exp 00", mole);
        end
        vecs++;
        if (spawn_count !== 8'd0) begin
            errs++; $display("FAIL async_count got %0d exp 0", spawn_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_game(e);
        cnt = 0;
        run_spawns(2, 8'h00, 0, 2'b01, e, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        lfa[0] = 16'hACE1;
        for (int i = 1; i < 16384; i++) begin
            lfa[i] = {1'b0, lfa[i-1][15:1]} ^ (lfa[i-1][0] ? 16'hB400 : 16'h0000);
        end
        test_reset();
        test_first_spawn();
        test_random();
        test_blocked();
        test_cap();
        test_diff_change();
        test_enable_drop();
        test_saturate();
        test_reset_fire();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
